pc_update_unit: RTL

Program-counter register stage that consumes the 32-bit target chosen by the PC-source mux and decides whether, and when, the PC takes it. It evaluates the conditional-write rule for beq/bne/ble/bgt and captures EPC on exceptions. It also runs a small FSM that fetches the exception handler address byte from memory and loads it into the PC. Sits between the PC-source mux and the instruction-memory address path; `busy` stalls the control unit while a vector fetch is in flight.

---
 rtl/pc_update_unit.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pc_update_unit.sv
// PC register stage: conditional branch write, EPC capture and exception-vector fetch FSM.
// Optional build macro PCU_ALIGN_CHK_EN turns a misaligned PC write into an internal code-3 exception.
module pc_update_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] VEC_BASE = 32'd253,
  parameter int unsigned MEM_LAT  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_next,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic [1:0]  branch_op,
  input  logic        alu_zero,
  input  logic        alu_gt,
  input  logic        exc_req,
  input  logic [1:0]  exc_code,
  input  logic [7:0]  mem_rdata,
  output logic [31:0] pc,
  output logic [31:0] epc,
  output logic [31:0] vec_addr,
  output logic        vec_rd,
  output logic        busy,
  output logic        exc_done,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    VEC_REQ  = 2'd1,
    VEC_WAIT = 2'd2,
    VEC_LOAD = 2'd3
  } state_t;

  localparam logic [2:0] WAIT_INIT = 3'(MEM_LAT - 1);

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic        cond;
  logic        take;
  logic        exc_go;
  logic        pc_load;
  logic [1:0]  exc_sel;

  always_comb begin
    cond = 1'b0;
    case (branch_op)
      2'b00:   cond = alu_zero;
      2'b01:   cond = ~alu_zero;
      2'b10:   cond = alu_zero | ~alu_gt;
      default: cond = alu_gt & ~alu_zero;
    endcase
  end

  assign take = pc_write | (pc_write_cond & cond);

`ifdef PCU_ALIGN_CHK_EN
  logic misalign;
  assign misalign = take & (pc_next[1:0] != 2'b00);
  assign exc_go   = exc_req | misalign;
  assign exc_sel  = exc_req ? exc_code : 2'd3;
  assign pc_load  = take & ~misalign;
`else
  assign exc_go   = exc_req;
  assign exc_sel  = exc_code;
  assign pc_load  = take;
`endif

  // Vector fetch protocol: vec_rd is a one-cycle strobe with no handshake back;
  // mem_rdata is assumed valid exactly MEM_LAT cycles later, which is the VEC_LOAD cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (exc_go) state_nxt = VEC_REQ;
      end
      VEC_REQ: begin
        if (MEM_LAT > 1) begin
          state_nxt = VEC_WAIT;
          cnt_nxt   = WAIT_INIT;
        end else begin
          state_nxt = VEC_LOAD;
        end
      end
      VEC_WAIT: begin
        if (cnt <= 3'd1) begin
          state_nxt = VEC_LOAD;
          cnt_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      VEC_LOAD: state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      cnt      <= 3'd0;
      pc       <= RESET_PC;
      epc      <= 32'd0;
      vec_addr <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      case (state)
        RUN: begin
          // Exception wins over a same-cycle PC write; the PC holds until the handler loads.
          if (exc_go) begin
            epc      <= pc - 32'd4;
            vec_addr <= VEC_BASE + {30'd0, exc_sel};
          end else if (pc_load) begin
            pc <= pc_next;
          end
        end
        VEC_LOAD: begin
          pc       <= {24'd0, mem_rdata};
          vec_addr <= 32'd0;
        end
        default: ;
      endcase
    end
  end

  assign vec_rd    = (state == VEC_REQ);
  assign busy      = (state != RUN);
  assign exc_done  = (state == VEC_LOAD);
  assign state_dbg = state;

endmodule
